// File: rtl/duty_scaler.sv
// duty_scaler: samples raw RGB duties and a global brightness once per PWM period,
// scales each channel with a serial shift-add multiplier, and commits the scaled
// duties to the outputs only at the period boundary so pwm never sees a mid-period change.
module duty_scaler #(
  parameter int unsigned PWM_INTERVAL = 1200,
  localparam int unsigned W = $clog2(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] R_in,
  input  logic [W-1:0] G_in,
  input  logic [W-1:0] B_in,
  input  logic [7:0]   brightness,
  output logic [W-1:0] R_value,
  output logic [W-1:0] G_value,
  output logic [W-1:0] B_value,
  output logic         period_start,
  output logic         busy
);

  localparam int unsigned P = W + 9;  // full product width
  localparam logic [W-1:0] CntLast = W'(PWM_INTERVAL - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e         state;
  logic [W-1:0]   period_cnt;
  logic [W-1:0]   cap_r, cap_g, cap_b;
  logic [8:0]     cap_mult;
  logic [1:0]     ch;
  logic [3:0]     bit_idx;
  logic [P-1:0]   acc;
  logic [W-1:0]   pend_r, pend_g, pend_b;
  logic           pend_valid;

  logic [W-1:0]   cur_in;
  logic [P-1:0]   addend;
  logic [P-1:0]   acc_sum;
  logic [W-1:0]   result;

  // Period counter, free-running in lockstep with pwm from reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (period_cnt == CntLast) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 1'b1;
    end
  end

  // Multiplier datapath: select the channel operand and form this cycle's partial sum
  always_comb begin
    cur_in = '0;
    case (ch)
      2'd0:    cur_in = cap_r;
      2'd1:    cur_in = cap_g;
      2'd2:    cur_in = cap_b;
      default: cur_in = '0;
    endcase
    addend  = cap_mult[bit_idx] ? ({{9{1'b0}}, cur_in} << bit_idx) : '0;
    acc_sum = acc + addend;
    // >> 8 then truncate to W bits
    result  = acc_sum[W+7:8];
  end

  // Capture / serial multiply FSM plus period-boundary commit of the scaled duties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      cap_r      <= '0;
      cap_g      <= '0;
      cap_b      <= '0;
      cap_mult   <= '0;
      ch         <= '0;
      bit_idx    <= '0;
      acc        <= '0;
      pend_r     <= '0;
      pend_g     <= '0;
      pend_b     <= '0;
      pend_valid <= 1'b0;
      R_value    <= '0;
      G_value    <= '0;
      B_value    <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (period_cnt == '0) begin
            cap_r    <= R_in;
            cap_g    <= G_in;
            cap_b    <= B_in;
            cap_mult <= {1'b0, brightness} + 9'd1;
            ch       <= 2'd0;
            bit_idx  <= '0;
            acc      <= '0;
            state    <= StMul;
          end
        end
        StMul: begin
          if (bit_idx == 4'd8) begin
            acc     <= '0;
            bit_idx <= '0;
            case (ch)
              2'd0:    pend_r <= result;
              2'd1:    pend_g <= result;
              default: pend_b <= result;
            endcase
            if (ch == 2'd2) begin
              state <= StDone;
            end else begin
              ch <= ch + 2'd1;
            end
          end else begin
            acc     <= acc_sum;
            bit_idx <= bit_idx + 4'd1;
          end
        end
        StDone: begin
          pend_valid <= 1'b1;
          state      <= StIdle;
        end
        default: state <= StIdle;
      endcase

      // Multiply ends at count 28, far from the commit count, so these never overlap
      if (period_cnt == CntLast && pend_valid) begin
        R_value    <= pend_r;
        G_value    <= pend_g;
        B_value    <= pend_b;
        pend_valid <= 1'b0;
      end
    end
  end

  // Status outputs; period_start is gated by rst_n so it reads 0 while held in reset
  always_comb begin
    busy         = (state != StIdle);
    period_start = rst_n && (period_cnt == '0);
  end

endmodule

// File: tb/tb_duty_scaler.sv
// Scoreboard bench for duty_scaler: stimulus pushes the expected duties for each
// upcoming period, a monitor pops and compares them at every period_start.
module tb_duty_scaler;

  localparam int unsigned PwmInterval = 1200;
  localparam int unsigned W = 11;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] R_in, G_in, B_in;
  logic [7:0]   brightness;
  logic [W-1:0] R_value, G_value, B_value;
  logic         period_start;
  logic         busy;

  duty_scaler #(.PWM_INTERVAL(PwmInterval)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .R_in         (R_in),
    .G_in         (G_in),
    .B_in         (B_in),
    .brightness   (brightness),
    .R_value      (R_value),
    .G_value      (G_value),
    .B_value      (B_value),
    .period_start (period_start),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int r;
    int g;
    int b;
    int br;
    int er;
    int eg;
    int eb;
  } vec_t;

  typedef struct {
    int r;
    int g;
    int b;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  int n_tests = 0;
  int n_fail  = 0;
  int glitches = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int r, input int g, input int b);
    exp_t e;
    e.r = r;
    e.g = g;
    e.b = b;
    sb_q.push_back(e);
  endtask

  task automatic apply(input int i);
    R_in       = W'(vecs[i].r);
    G_in       = W'(vecs[i].g);
    B_in       = W'(vecs[i].b);
    brightness = 8'(vecs[i].br);
  endtask

  // Advance to the next negedge that shows period_start, bounded by a cycle budget
  task automatic wait_ps();
    int n;
    n = 0;
    @(negedge clk);
    while (!period_start && n < PwmInterval + 100) begin
      @(negedge clk);
      n++;
    end
    if (!period_start) begin
      n_tests++;
      n_fail++;
      $display("FAIL period_start_timeout: got no pulse, expected one within %0d cycles",
               PwmInterval + 100);
    end
  endtask

  // Monitor: scoreboard pop at period boundaries, period length, busy width, stray toggles
  initial begin
    int cyc;
    int busy_cnt;
    bit seen;
    bit prev_valid;
    int pr, pg, pb;
    exp_t e;
    cyc = 0; busy_cnt = 0; seen = 0; prev_valid = 0; pr = 0; pg = 0; pb = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen       = 0;
        prev_valid = 0;
      end else begin
        if (period_start) begin
          if (seen) begin
            check("period_length", cyc, PwmInterval);
            check("busy_cycles", busy_cnt, 28);
          end
          seen     = 1;
          cyc      = 1;
          busy_cnt = busy ? 1 : 0;
          if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("R_value", int'(R_value), e.r);
            check("G_value", int'(G_value), e.g);
            check("B_value", int'(B_value), e.b);
          end
        end else begin
          cyc++;
          if (busy) busy_cnt++;
          if (prev_valid && (int'(R_value) != pr || int'(G_value) != pg ||
                             int'(B_value) != pb)) begin
            glitches++;
          end
        end
        pr = int'(R_value);
        pg = int'(G_value);
        pb = int'(B_value);
        prev_valid = 1;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // r, g, b, brightness -> hand-computed (in * (br+1)) >> 8
    vecs[0] = '{1199, 600, 0, 255, 1199, 600, 0};
    // 1000*129=129000>>8=503, 3*129=387>>8=1, 1199*129=154671>>8=604
    vecs[1] = '{1000, 3, 1199, 128, 503, 1, 604};
    // brightness 0: in >> 8
    vecs[2] = '{1000, 3, 1199, 0, 3, 0, 4};
    vecs[3] = '{100, 50, 70, 255, 100, 50, 70};
    vecs[4] = '{900, 50, 70, 255, 900, 50, 70};
    // 1199*65=77935>>8=304, 600*65=39000>>8=152
    vecs[5] = '{1199, 600, 0, 64, 304, 152, 0};

    apply(0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_R", int'(R_value), 0);
    check("reset_G", int'(G_value), 0);
    check("reset_B", int'(B_value), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_period_start", int'(period_start), 0);
    repeat (2) @(negedge clk);

    // First period shows 0, second shows the values sampled at release
    push_exp(0, 0, 0);
    push_exp(vecs[0].er, vecs[0].eg, vecs[0].eb);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Each new vector is applied at count 500, sampled at the next count 0
    for (int i = 1; i < 5; i++) begin
      wait_ps();
      repeat (500) @(negedge clk);
      apply(i);
      push_exp(vecs[i].er, vecs[i].eg, vecs[i].eb);
    end

    // Reset in the middle of the multiply
    wait_ps();
    repeat (10) @(negedge clk);
    check("busy_mid_multiply", int'(busy), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_R", int'(R_value), 0);
    check("async_reset_G", int'(G_value), 0);
    check("async_reset_B", int'(B_value), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_period_start", int'(period_start), 0);
    sb_q.delete();
    apply(5);
    repeat (3) @(posedge clk);
    push_exp(0, 0, 0);
    push_exp(vecs[5].er, vecs[5].eg, vecs[5].eb);
    push_exp(vecs[5].er, vecs[5].eg, vecs[5].eb);
    #2 rst_n = 1'b1;

    repeat (3) wait_ps();
    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("off_boundary_toggles", glitches, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
